key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 3, number of independent input channels (sw[0] increment, sw[2:1] select).
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, debounce stability interval (10 ms at 100 MHz), minimum 1.
REQ-003 SHALL have parameter DELAY_CYCLES, default 50000000, hold time before auto-repeat starts (500 ms), minimum 1.
REQ-004 SHALL have parameter RATE_CYCLES, default 10000000, auto-repeat period (100 ms), minimum 1.
REQ-005 SHALL have port clk100MHz, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port raw, input, WIDTH, asynchronous switch/button levels.
REQ-008 SHALL have port level, output, WIDTH, debounced level per channel.
REQ-009 SHALL have port press, output, WIDTH, one-cycle pulse on debounced 0->1.
REQ-010 SHALL have port release, output, WIDTH, one-cycle pulse on debounced 1->0.
REQ-011 SHALL have port rpt, output, WIDTH, one-cycle pulse per press plus each auto-repeat tick; drives Clock increment.

Function
REQ-012 SHALL pass each raw bit through a two-flop synchronizer before any other logic.
REQ-013 SHALL count consecutive cycles where synchronized input differs from level; count clears on any cycle they match.
REQ-014 SHALL toggle level when DB_CYCLES consecutive differing cycles accumulate, i.e. level changes on the (2+DB_CYCLES)th rising edge after raw settles.
REQ-015 SHALL ignore any raw pulse or glitch shorter than DB_CYCLES synchronized cycles: no level change, no pulses.
REQ-016 SHALL assert press (resp. release) only during the first cycle level is 1 (resp. 0).
REQ-017 SHALL run per-channel repeat FSM, states IDLE, DELAY, REPEAT.
REQ-018 IDLE -> DELAY on level rise; rpt asserted in that same cycle as press.
REQ-019 DELAY -> REPEAT after DELAY_CYCLES cycles after the press cycle; rpt pulses on that cycle.
REQ-020 In REPEAT, rpt SHALL pulse every RATE_CYCLES cycles while level stays 1; counter reloads, never wraps or saturates.
REQ-021 Any state -> IDLE in the cycle level falls; counters clear; no rpt in that cycle or after.
REQ-022 Release coinciding with a due repeat tick: release SHALL win, rpt not asserted.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-024 At most one of press/release per channel per cycle; rpt never asserted while level is 0.

Reset
REQ-025 reset low SHALL immediately force synchronizers, counters, level, press, release, rpt to 0 and FSMs to IDLE.
REQ-026 Reset mid-operation (any FSM state) SHALL abandon it; no pulse emitted during or on release of reset.
REQ-027 Raw held high across reset deassertion SHALL be treated as a new press after 2+DB_CYCLES edges.

Structure
REQ-028 FSM state encodings and default cycle counts SHALL live in the shared constants include file, prefixed KC_.
REQ-029 Per-channel logic SHALL be sub-module key_channel, instantiated WIDTH times by key_conditioner.
REQ-030 Counter widths SHALL be sized by clog2 of the largest of DB/DELAY/RATE parameters.

Verification (WIDTH=3, DB_CYCLES=4, DELAY_CYCLES=20, RATE_CYCLES=5)
REQ-031 raw[0] 0->1 before edge 0, held -> level[0], press[0], rpt[0] at edge 6; rpt[0] at edges 26, 31, 36 ...
REQ-032 raw[1] high for 3 cycles then low -> level, press, release, rpt stay 0 throughout.
REQ-033 raw[0] held 40 cycles then low -> level[0] falls and release[0] pulses 6 edges later; no rpt after.
REQ-034 reset low during REPEAT with raw[0] high -> all outputs 0 at once; after deassert, press[0] and rpt[0] 6 edges later.
REQ-035 Release timed to land on a repeat tick -> release[0] only, rpt[0] 0 that cycle.
REQ-036 raw[0] held, raw[2] pressed 10 cycles later -> channel 2 pulses on its own timeline; channel 0 repeat timing unaffected.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared constants and repeat FSM encoding for key_conditioner
package key_conditioner_pkg;

  localparam int KC_WIDTH        = 3;
  localparam int KC_DB_CYCLES    = 1000000;
  localparam int KC_DELAY_CYCLES = 50000000;
  localparam int KC_RATE_CYCLES  = 10000000;

  typedef enum logic [1:0] {
    KC_IDLE   = 2'd0,
    KC_DELAY  = 2'd1,
    KC_REPEAT = 2'd2
  } kc_state_e;

  // One counter width serves debounce and repeat timing alike.
  function automatic int kc_cnt_width(input int db, input int dl, input int rt);
    int m;
    m = db;
    if (dl > m) m = dl;
    if (rt > m) m = rt;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one input channel: synchronizer, debouncer, edge pulses, auto-repeat
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DB_CYCLES    = KC_DB_CYCLES,
  parameter int DELAY_CYCLES = KC_DELAY_CYCLES,
  parameter int RATE_CYCLES  = KC_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int CW = kc_cnt_width(DB_CYCLES, DELAY_CYCLES, RATE_CYCLES);
  localparam logic [CW-1:0] DB_MAX     = CW'(DB_CYCLES);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(RATE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] rep_cnt, rep_cnt_nx;
  kc_state_e     state, state_nx;
  logic          rpt_nx;
  logic          toggle, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Toggle once DB_CYCLES differing samples have already accumulated.
  assign toggle = (sync2 != level) && (db_cnt == DB_MAX);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt        <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (toggle) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= KC_IDLE;
      rep_cnt <= '0;
      rpt     <= 1'b0;
    end else begin
      state   <= state_nx;
      rep_cnt <= rep_cnt_nx;
      rpt     <= rpt_nx;
    end
  end

  // A falling level outranks any repeat tick due in the same cycle.
  always_comb begin
    state_nx   = state;
    rep_cnt_nx = rep_cnt;
    rpt_nx     = 1'b0;
    if (fall) begin
      state_nx   = KC_IDLE;
      rep_cnt_nx = '0;
    end else begin
      case (state)
        KC_IDLE: begin
          if (rise) begin
            state_nx   = KC_DELAY;
            rep_cnt_nx = '0;
            rpt_nx     = 1'b1;
          end
        end
        KC_DELAY: begin
          if (rep_cnt == DELAY_LAST) begin
            state_nx   = KC_REPEAT;
            rep_cnt_nx = '0;
            rpt_nx     = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
        KC_REPEAT: begin
          if (rep_cnt == RATE_LAST) begin
            rep_cnt_nx = '0;
            rpt_nx     = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
        default: begin
          state_nx   = KC_IDLE;
          rep_cnt_nx = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - WIDTH independent debounced key channels with auto-repeat
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int WIDTH        = KC_WIDTH,
  parameter int DB_CYCLES    = KC_DB_CYCLES,
  parameter int DELAY_CYCLES = KC_DELAY_CYCLES,
  parameter int RATE_CYCLES  = KC_RATE_CYCLES
) (
  input  logic             clk100MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] rpt
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    key_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .DELAY_CYCLES(DELAY_CYCLES),
      .RATE_CYCLES (RATE_CYCLES)
    ) u_ch (
      .clk          (clk100MHz),
      .rst_n        (reset),
      .raw          (raw[g]),
      .level        (level[g]),
      .press        (press[g]),
      .release_pulse(release_pulse[g]),
      .rpt          (rpt[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner with a segment-level reference model
module tb_key_conditioner;

  localparam int W    = 3;
  localparam int DB   = 4;
  localparam int DL   = 20;
  localparam int RT   = 5;
  localparam int MAXN = 512;

  typedef struct {
    int           n;
    logic [W-1:0] lvl;
    logic [W-1:0] prs;
    logic [W-1:0] rls;
    logic [W-1:0] rpt;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw;
  logic [W-1:0] level, press, release_pulse, rpt;

  logic [W-1:0] plan  [MAXN];
  logic [W-1:0] e_lvl [MAXN];
  logic [W-1:0] e_prs [MAXN];
  logic [W-1:0] e_rls [MAXN];
  logic [W-1:0] e_rpt [MAXN];
  ev_t          q[$];

  int   cyc = 0;
  int   base = 0;
  logic mon_en = 1'b0;
  int   end_req = 0;
  int   end_seen = 0;
  int   checks = 0;
  int   failures = 0;
  int   mon_edge;
  ev_t  mon_ev;

  key_conditioner #(
    .WIDTH(W), .DB_CYCLES(DB), .DELAY_CYCLES(DL), .RATE_CYCLES(RT)
  ) dut (
    .clk100MHz    (clk),
    .reset        (reset),
    .raw          (raw),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .rpt          (rpt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic emit_rpt(input int ch, input int r, input int stop);
    e_rpt[r][ch] = 1'b1;
    for (int t = r + DL; t < stop; t += RT) e_rpt[t][ch] = 1'b1;
  endtask

  // Raw is a run of constant segments; a segment opposing the level and lasting
  // at least DB+1 samples flips the level DB+2 edges after it starts.
  task automatic build_expected(input int n_cyc);
    for (int n = 0; n < MAXN; n++) begin
      e_lvl[n] = '0; e_prs[n] = '0; e_rls[n] = '0; e_rpt[n] = '0;
    end
    for (int ch = 0; ch < W; ch++) begin
      logic lvl;
      logic v;
      int   r, t0, t1, tt;
      lvl = 1'b0; r = -1; t0 = 0;
      while (t0 < n_cyc) begin
        v  = plan[t0][ch];
        t1 = t0;
        while (t1 < n_cyc && plan[t1][ch] == v) t1++;
        tt = t0 + 2 + DB;
        if (v != lvl && (t1 - t0) >= DB + 1 && tt < n_cyc) begin
          if (v) begin
            e_prs[tt][ch] = 1'b1;
            r = tt;
          end else begin
            e_rls[tt][ch] = 1'b1;
            emit_rpt(ch, r, tt);
            r = -1;
          end
          for (int n = tt; n < n_cyc; n++) e_lvl[n][ch] = v;
          lvl = v;
        end
        t0 = t1;
      end
      if (r >= 0) emit_rpt(ch, r, n_cyc);
    end
  endtask

  task automatic gen_random(input int n_cyc);
    for (int ch = 0; ch < W; ch++) begin
      int   t, len;
      logic v;
      t = 0;
      v = 1'($urandom_range(0, 1));
      while (t < n_cyc) begin
        if ($urandom_range(0, 9) < 7) len = int'($urandom_range(1, DB + 3));
        else                          len = int'($urandom_range(DB + 1, 60));
        for (int k = 0; k < len && t < n_cyc; k++) begin
          plan[t][ch] = v;
          t++;
        end
        v = ~v;
      end
    end
  endtask

  task automatic run_plan(input int n_cyc);
    ev_t ev;
    build_expected(n_cyc);
    for (int n = 0; n < n_cyc; n++) begin
      if ((e_prs[n] | e_rls[n] | e_rpt[n]) != '0) begin
        ev.n = n; ev.lvl = e_lvl[n]; ev.prs = e_prs[n]; ev.rls = e_rls[n]; ev.rpt = e_rpt[n];
        q.push_back(ev);
      end
    end
    reset = 1'b0;
    raw   = plan[0];
    repeat (2) begin @(posedge clk); #2; end
    reset  = 1'b1;
    base   = cyc + 1;
    mon_en = 1'b1;
    for (int n = 0; n < n_cyc; n++) begin
      raw = plan[n];
      @(posedge clk); #2;
    end
    @(negedge clk); #1;
    mon_en  = 1'b0;
    end_req = end_req + 1;
    @(negedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits any pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        checks++;
        if ((level | press | release_pulse | rpt) !== '0) begin
          failures++;
          $display("FAIL reset_outputs level=%b press=%b release=%b rpt=%b required all 0",
                   level, press, release_pulse, rpt);
        end
      end
      if (end_req != end_seen) begin
        end_seen = end_req;
        checks++;
        if (q.size() != 0) begin
          failures++;
          $display("FAIL events_pending left=%0d required 0 (first edge %0d)", q.size(), q[0].n);
          q.delete();
        end
      end
      if (mon_en) begin
        mon_edge = cyc - base;
        while (q.size() > 0 && q[0].n < mon_edge) begin
          checks++;
          failures++;
          $display("FAIL missed_event edge=%0d required press=%b release=%b rpt=%b, not observed",
                   q[0].n, q[0].prs, q[0].rls, q[0].rpt);
          void'(q.pop_front());
        end
        if ((press | release_pulse | rpt) != '0) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event edge=%0d press=%b release=%b rpt=%b required no pulse",
                     mon_edge, press, release_pulse, rpt);
          end else begin
            mon_ev = q.pop_front();
            if (mon_ev.n != mon_edge || mon_ev.lvl !== level || mon_ev.prs !== press ||
                mon_ev.rls !== release_pulse || mon_ev.rpt !== rpt) begin
              failures++;
              $display("FAIL event edge=%0d level=%b press=%b release=%b rpt=%b required edge=%0d level=%b press=%b release=%b rpt=%b",
                       mon_edge, level, press, release_pulse, rpt,
                       mon_ev.n, mon_ev.lvl, mon_ev.prs, mon_ev.rls, mon_ev.rpt);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    raw   = '0;

    // ch0 held 40 cycles (release lands on a repeat tick), ch1 short glitch, ch2 later press.
    for (int n = 0; n < 90; n++) begin
      plan[n][0] = (n < 40);
      plan[n][1] = (n >= 5 && n < 8);
      plan[n][2] = (n >= 10 && n < 60);
    end
    run_plan(90);

    // Reach REPEAT on ch0, then reset mid-operation with raw still high.
    for (int n = 0; n < 36; n++) plan[n] = 3'b001;
    run_plan(36);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #2; end

    for (int n = 0; n < 45; n++) plan[n] = 3'b001;
    run_plan(45);

    for (int k = 0; k < 4; k++) begin
      gen_random(300);
      run_plan(300);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
